// File: rtl/char_line_scheduler.sv
// ============================================================================
// char_line_scheduler
//
// Sequencer and round-robin arbiter that sits in front of the VGA character
// drawing block. Two text producers (0: target-word display, 1: typed-text
// echo) each fill a private buffer of character addresses. Each then raises a
// level request to have the line plotted. The scheduler grants the shared
// drawer to one producer at a time. It issues one character plot per drawer
// handshake, advancing x by CHAR_W pixels per character, and pulses doneN once
// the whole line has been handed to the drawer.
//
// Parameters
//   MAX_LEN  buffer depth per requester (power of two, >= 2)
//   CHAR_W   x advance per character, pixels
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   wr_en*/wr_idx*/wr_data*     buffer write port, one per requester
//   req*                        level request to plot the loaded line
//   x*, y*, len*                line origin and character count (0..31)
//   gnt*                        requester owns the drawer (ISSUE..DONE)
//   done*                       one-cycle pulse, line complete
//   busy                        scheduler is not idle
//   address, x_input, y_input   character and origin presented to the drawer
//   enable_character_plot       one-cycle start pulse to the drawer
//   ready_to_start_character    drawer idle / previous plot finished
// ============================================================================
module char_line_scheduler #(
    parameter int MAX_LEN = 16,
    parameter int CHAR_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en0,
    input  logic [$clog2(MAX_LEN)-1:0] wr_idx0,
    input  logic [7:0]                 wr_data0,
    input  logic                       wr_en1,
    input  logic [$clog2(MAX_LEN)-1:0] wr_idx1,
    input  logic [7:0]                 wr_data1,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [8:0]                 x0,
    input  logic [8:0]                 y0,
    input  logic [4:0]                 len0,
    input  logic [8:0]                 x1,
    input  logic [8:0]                 y1,
    input  logic [4:0]                 len1,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic                       done0,
    output logic                       done1,
    output logic                       busy,
    output logic [7:0]                 address,
    output logic [8:0]                 x_input,
    output logic [8:0]                 y_input,
    output logic                       enable_character_plot,
    input  logic                       ready_to_start_character
);

    localparam int IW = $clog2(MAX_LEN);
    // One extra bit so the character counter can hold MAX_LEN itself.
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   len_eff_q, len_eff_d;
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [8:0]      x_base_q, x_base_d;
    logic [8:0]      y_base_q, y_base_d;

    logic [7:0]      buf0_q [MAX_LEN];
    logic [7:0]      buf0_d [MAX_LEN];
    logic [7:0]      buf1_q [MAX_LEN];
    logic [7:0]      buf1_d [MAX_LEN];

    logic            winner;
    logic [4:0]      win_len;
    logic [CW-1:0]   win_len_eff;
    logic [8:0]      x_off;

    assign busy = (state_q != ST_IDLE);
    assign gnt0 = busy && !owner_q;
    assign gnt1 = busy && owner_q;

    // Round-robin pick: a lone request wins outright; with both pending the
    // requester that was not served last goes first. The winner's length is
    // clamped to the buffer depth here so the FSM only ever sees a legal count.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_owner_q;
        end else begin
            winner = req1;
        end
        win_len = winner ? len1 : len0;
        if (int'(win_len) > MAX_LEN) begin
            win_len_eff = CW'(MAX_LEN);
        end else begin
            win_len_eff = CW'(win_len);
        end
    end

    // Pixel offset of the current character; the 9-bit truncation gives the
    // intended wrap at the right edge of the 512-wide coordinate space.
    always_comb begin
        x_off = 9'(int'(idx_q) * CHAR_W);
    end

    // Buffer writes. The buffer of the line currently being drawn is frozen so
    // the plotted characters cannot change mid-line; the other buffer is free.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (wr_en0 && !gnt0) begin
            buf0_d[wr_idx0] = wr_data0;
        end
        if (wr_en1 && !gnt1) begin
            buf1_d[wr_idx1] = wr_data1;
        end
    end

    // Main sequencer. The drawer handshake is: pulse while ready is high,
    // wait for ready to fall (drawer accepted), then wait for it to rise
    // (drawer finished) before moving on to the next character.
    always_comb begin
        state_d               = state_q;
        idx_d                 = idx_q;
        len_eff_d             = len_eff_q;
        owner_d               = owner_q;
        last_owner_d          = last_owner_q;
        x_base_d              = x_base_q;
        y_base_d              = y_base_q;
        address               = 8'd0;
        x_input               = 9'd0;
        y_input               = 9'd0;
        enable_character_plot = 1'b0;
        done0                 = 1'b0;
        done1                 = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d   = winner;
                    x_base_d  = winner ? x1 : x0;
                    y_base_d  = winner ? y1 : y0;
                    len_eff_d = win_len_eff;
                    idx_d     = '0;
                    state_d   = (win_len_eff == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                address               = owner_q ? buf1_q[idx_q[IW-1:0]]
                                                : buf0_q[idx_q[IW-1:0]];
                x_input               = x_base_q + x_off;
                y_input               = y_base_q;
                enable_character_plot = ready_to_start_character;
                if (ready_to_start_character) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!ready_to_start_character) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (ready_to_start_character) begin
                    idx_d   = idx_q + CW'(1);
                    state_d = (idx_d == len_eff_q) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done0        = !owner_q;
                done1        = owner_q;
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers. last_owner resets to 1 so requester 0 wins the very
    // first contended arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_eff_q    <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            x_base_q     <= 9'd0;
            y_base_q     <= 9'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_eff_q    <= len_eff_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            x_base_q     <= x_base_d;
            y_base_q     <= y_base_d;
        end
    end

    // Character buffers have no reset so loaded text survives a reset.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

endmodule

// File: tb/tb_char_line_scheduler.sv
// ============================================================================
// tb_char_line_scheduler
//
// Self-checking bench for char_line_scheduler. A small drawer model answers
// the plot handshake with a programmable busy time. Expected plots and done
// pulses come from a line-level reference model: each granted line yields
// min(len, MAX_LEN) plots of (owner, buf[i], (x + i*CHAR_W) mod 512, y).
// Under contention, grants alternate starting with whichever requester was
// not served last.
// ============================================================================
module tb_char_line_scheduler;

    localparam int MAX_LEN = 16;
    localparam int CHAR_W  = 8;
    localparam int IW      = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en0, wr_en1;
    logic [IW-1:0] wr_idx0, wr_idx1;
    logic [7:0]    wr_data0, wr_data1;
    logic          req0, req1;
    logic [8:0]    x0, y0, x1, y1;
    logic [4:0]    len0, len1;
    logic          gnt0, gnt1, done0, done1, busy;
    logic [7:0]    address;
    logic [8:0]    x_input, y_input;
    logic          enable_character_plot;
    logic          ready_to_start_character;

    char_line_scheduler #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .wr_en0                   (wr_en0),
        .wr_idx0                  (wr_idx0),
        .wr_data0                 (wr_data0),
        .wr_en1                   (wr_en1),
        .wr_idx1                  (wr_idx1),
        .wr_data1                 (wr_data1),
        .req0                     (req0),
        .req1                     (req1),
        .x0                       (x0),
        .y0                       (y0),
        .len0                     (len0),
        .x1                       (x1),
        .y1                       (y1),
        .len1                     (len1),
        .gnt0                     (gnt0),
        .gnt1                     (gnt1),
        .done0                    (done0),
        .done1                    (done1),
        .busy                     (busy),
        .address                  (address),
        .x_input                  (x_input),
        .y_input                  (y_input),
        .enable_character_plot    (enable_character_plot),
        .ready_to_start_character (ready_to_start_character)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: buffer images and the last served requester.
    logic [7:0]  model_buf [2][MAX_LEN];
    logic        model_last;
    logic [26:0] exp_plots [$];
    logic [26:0] obs_plots [$];
    int          exp_done  [$];
    int          obs_done  [$];

    int          cyc = 0;
    int          tick_no = 0;
    int          last_plot_tick = -100;
    int          last_rise_cyc = 0;
    int          last_done_cyc = 0;
    int          idle_viol = 0;
    int          spacing_viol = 0;
    int          gnt1_seen = 0;
    int          drawer_busy = 3;
    int          drawer_cnt = 0;
    logic        fire_r = 1'b0;
    logic [1:0]  lat_gnt;
    logic        lat_en;
    logic [1:0]  lat_done;
    bit          blk_pending = 0;
    bit          blk_clear = 0;
    logic [7:0]  blk_new1;

    // Cycle counter used to time done pulses against drawer ready edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Remember whether the scheduler pulsed the drawer at this edge.
    always @(posedge clk) fire_r <= enable_character_plot;

    // Drawer model: drops ready just after accepting a pulse, stays busy for
    // drawer_busy cycles, then raises ready again. It ignores scheduler reset.
    initial begin
        ready_to_start_character = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (fire_r) begin
                ready_to_start_character = 1'b0;
                drawer_cnt = drawer_busy;
            end else if (!ready_to_start_character) begin
                if (drawer_cnt <= 1) begin
                    ready_to_start_character = 1'b1;
                    last_rise_cyc = cyc;
                end else begin
                    drawer_cnt--;
                end
            end
        end
    end

    // Global time bound so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and sample the DUT at the falling edge, logging plots
    // and done pulses and recording protocol-rule violations.
    task automatic tick();
        @(negedge clk);
        tick_no++;
        if (enable_character_plot) begin
            obs_plots.push_back({gnt1, address, x_input, y_input});
            if (tick_no - last_plot_tick < 3) spacing_viol++;
            last_plot_tick = tick_no;
            if (!ready_to_start_character) idle_viol++;
        end
        if (done0) obs_done.push_back(0);
        if (done1) obs_done.push_back(1);
        if (done0 || done1) last_done_cyc = cyc;
        if (done0 && done1) idle_viol++;
        if (gnt0 && gnt1) idle_viol++;
        if (busy !== (gnt0 | gnt1)) idle_viol++;
        if (!gnt0 && !gnt1 && (address != 8'd0 || x_input != 9'd0 ||
                               y_input != 9'd0 || enable_character_plot))
            idle_viol++;
        if (gnt1) gnt1_seen++;
    endtask

    task automatic write_buf(input int n, input int idx, input logic [7:0] data);
        if (n == 0) begin
            wr_en0 = 1'b1; wr_idx0 = IW'(idx); wr_data0 = data;
        end else begin
            wr_en1 = 1'b1; wr_idx1 = IW'(idx); wr_data1 = data;
        end
        tick();
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
        model_buf[n][idx] = data;
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < MAX_LEN; i++) write_buf(n, i, 8'($urandom));
    endtask

    // Line-level expectation straight from the plotting rule.
    task automatic expect_line(input int n, input int x, input int y, input int len);
        int eff;
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < eff; i++)
            exp_plots.push_back({1'(n), model_buf[n][i], 9'((x + i * CHAR_W) % 512), 9'(y)});
        exp_done.push_back(n);
    endtask

    task automatic compare_results(input string tag);
        checkOutput({tag, "_nplots"}, 32'(obs_plots.size()), 32'(exp_plots.size()));
        for (int i = 0; i < exp_plots.size() && i < obs_plots.size(); i++)
            checkOutput($sformatf("%s_plot%0d", tag, i), 32'(obs_plots[i]), 32'(exp_plots[i]));
        checkOutput({tag, "_ndone"}, 32'(obs_done.size()), 32'(exp_done.size()));
        for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++)
            checkOutput($sformatf("%s_done%0d", tag, i), 32'(obs_done[i]), 32'(exp_done[i]));
        exp_plots.delete();
        obs_plots.delete();
        exp_done.delete();
        obs_done.delete();
    endtask

    // Hold the chosen requests until n_lines done pulses have been seen, then
    // drop them so no further line starts. Expectations are built up front.
    task automatic applyStimulus(input string tag, input bit r0, input bit r1,
                                 input int n_lines,
                                 input int xa, input int ya, input int la,
                                 input int xb, input int yb, input int lb);
        int  start;
        int  budget;
        int  target;
        logic w;
        x0 = 9'(xa); y0 = 9'(ya); len0 = 5'(la);
        x1 = 9'(xb); y1 = 9'(yb); len1 = 5'(lb);
        for (int k = 0; k < n_lines; k++) begin
            w = (r0 && r1) ? ~model_last : r1;
            if (w) expect_line(1, xb, yb, lb);
            else   expect_line(0, xa, ya, la);
            model_last = w;
        end
        target = obs_done.size() + n_lines;
        budget = n_lines * 160 + 10;
        start  = tick_no;
        req0 = r0;
        req1 = r1;
        tick();
        lat_gnt  = {gnt1, gnt0};
        lat_en   = enable_character_plot;
        lat_done = {done1, done0};
        while (obs_done.size() < target && tick_no - start < budget) begin
            tick();
            if (blk_clear) begin
                wr_en0 = 1'b0;
                wr_en1 = 1'b0;
                blk_clear = 0;
            end else if (blk_pending && obs_plots.size() > 0) begin
                wr_en0 = 1'b1; wr_idx0 = IW'(1); wr_data0 = ~model_buf[0][1];
                wr_en1 = 1'b1; wr_idx1 = IW'(0); wr_data1 = blk_new1;
                model_buf[1][0] = blk_new1;
                blk_pending = 0;
                blk_clear = 1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput({tag, "_done_reached"}, 32'(obs_done.size() >= target), 32'd1);
        tick();
        checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int na;
        int xr, yr, lr, xs, ys, ls, nl;
        bit ra, rb;

        reset = 1'b1;
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_idx0 = '0; wr_idx1 = '0;
        wr_data0 = 8'd0; wr_data1 = 8'd0;
        req0 = 1'b0; req1 = 1'b0;
        x0 = 9'd0; y0 = 9'd0; x1 = 9'd0; y1 = 9'd0; len0 = 5'd0; len1 = 5'd0;
        model_last = 1'b1;
        repeat (3) tick();
        checkOutput("reset_outputs",
                    {busy, gnt0, gnt1, done0, done1, enable_character_plot,
                     address, x_input, y_input}, 32'd0);

        // Buffers survive reset, so fill them while reset is still held.
        load_random(0);
        load_random(1);
        reset = 1'b0;
        tick();
        obs_plots.delete();
        obs_done.delete();

        // Single line, known characters, drawer busy 5 cycles.
        drawer_busy = 5;
        write_buf(0, 0, 8'h41);
        write_buf(0, 1, 8'h42);
        write_buf(0, 2, 8'h43);
        gnt1_seen = 0;
        applyStimulus("single", 1, 0, 1, 10, 20, 3, 0, 0, 0);
        checkOutput("single_latency_gnt", 32'(lat_gnt), 32'd1);
        checkOutput("single_latency_pulse", 32'(lat_en), 32'd1);
        checkOutput("single_done_after_rise", 32'(last_done_cyc - last_rise_cyc), 32'd1);
        checkOutput("single_gnt1_never", 32'(gnt1_seen), 32'd0);
        if (obs_plots.size() == 3) begin
            checkOutput("single_plot2_addr", 32'(obs_plots[2][25:18]), 32'h43);
            checkOutput("single_plot2_x", 32'(obs_plots[2][17:9]), 32'd26);
        end
        compare_results("single");

        // Contention from a fresh reset: 0, 1, 0, 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last = 1'b1;
        obs_plots.delete();
        obs_done.delete();
        drawer_busy = 2;
        applyStimulus("contend", 1, 1, 4, 40, 50, 2, 100, 60, 2);
        checkOutput("contend_latency_gnt", 32'(lat_gnt), 32'd1);
        compare_results("contend");

        // Zero-length line: done in the very next cycle, nothing plotted.
        applyStimulus("len0", 1, 0, 1, 33, 44, 0, 0, 0, 0);
        checkOutput("len0_done_latency", 32'(lat_done), 32'd1);
        compare_results("len0");

        // Over-long line is clamped to the buffer depth.
        drawer_busy = 1;
        applyStimulus("len20", 1, 0, 1, 0, 100, 20, 0, 0, 0);
        compare_results("len20");

        // x wraps modulo 512.
        applyStimulus("xwrap", 1, 0, 1, 500, 7, 3, 0, 0, 0);
        if (obs_plots.size() == 3) begin
            checkOutput("xwrap_x1", 32'(obs_plots[1][17:9]), 32'd508);
            checkOutput("xwrap_x2", 32'(obs_plots[2][17:9]), 32'd4);
        end
        compare_results("xwrap");

        // Reset while waiting for the drawer after the second character.
        drawer_busy = 5;
        x0 = 9'd30; y0 = 9'd40; len0 = 5'd3;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 100 && obs_plots.size() < 2; i++) tick();
        checkOutput("abort_two_plots", 32'(obs_plots.size()), 32'd2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("abort_outputs",
                    {busy, gnt0, gnt1, done0, done1, enable_character_plot,
                     address, x_input, y_input}, 32'd0);
        reset = 1'b0;
        model_last = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("abort_no_done", 32'(obs_done.size()), 32'd0);
        obs_plots.delete();
        obs_done.delete();
        applyStimulus("restart", 1, 0, 1, 30, 40, 3, 0, 0, 0);
        compare_results("restart");

        // Writes during an active line 0: buf0 frozen, buf1 still writable.
        drawer_busy = 3;
        blk_new1 = ~model_buf[1][0];
        blk_pending = 1;
        applyStimulus("block0", 1, 0, 1, 200, 210, 3, 0, 0, 0);
        compare_results("block0");
        checkOutput("block_write_done", 32'(blk_pending), 32'd0);
        applyStimulus("block1", 0, 1, 1, 0, 0, 0, 300, 310, 2);
        if (obs_plots.size() >= 1)
            checkOutput("block1_new_data", 32'(obs_plots[0][25:18]), 32'(blk_new1));
        compare_results("block1");

        // Randomized traffic against the line-level model.
        for (int it = 0; it < 24; it++) begin
            drawer_busy = $urandom_range(1, 4);
            na = $urandom_range(0, 3);
            for (int k = 0; k < na; k++)
                write_buf($urandom_range(0, 1), $urandom_range(0, MAX_LEN - 1), 8'($urandom));
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1;
            xr = $urandom_range(0, 511); yr = $urandom_range(0, 511); lr = $urandom_range(0, 31);
            xs = $urandom_range(0, 511); ys = $urandom_range(0, 511); ls = $urandom_range(0, 31);
            nl = $urandom_range(1, 3);
            applyStimulus($sformatf("rand%0d", it), ra, rb, nl, xr, yr, lr, xs, ys, ls);
            compare_results($sformatf("rand%0d", it));
        end

        checkOutput("protocol_violations", 32'(idle_viol), 32'd0);
        checkOutput("plot_spacing_violations", 32'(spacing_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_line_scheduler.md
# char_line_scheduler

Sequencer and arbiter in front of the VGA character drawing block. Two text producers (target-word display, typed-text echo) each load a line of up to MAX_LEN character addresses into a private buffer. They then request a plot. The scheduler grants the shared drawer round-robin and issues one character plot at a time, advancing x by CHAR_W per character. It signals done when the whole line is drawn.

## Interface
Parameters:
- MAX_LEN, 16: buffer depth per requester (characters); power of two
- CHAR_W, 8: x advance per character, pixels

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en0 / wr_en1  in  1  buffer write strobe, requester 0 / 1
- wr_idx0 / wr_idx1  in  log2(MAX_LEN)  buffer write index
- wr_data0 / wr_data1  in  8  character address to store
- req0 / req1  in  1  level request to plot the loaded line
- x0 / x1, y0 / y1  in  9  start coordinates of the line
- len0 / len1  in  5  character count, 0..31
- gnt0 / gnt1  out  1  requester owns drawer (ISSUE..DONE)
- done0 / done1  out  1  one-cycle pulse: line complete
- busy  out  1  state != IDLE
- address  out  8  to drawer: character address
- x_input / y_input  out  9  to drawer: character origin
- enable_character_plot  out  1  to drawer: one-cycle start pulse
- ready_to_start_character  in  1  from drawer: idle / previous plot done

## Operation
- Buffers: two MAX_LEN x 8 register arrays.
  - A write lands at the clk edge when wr_enN=1.
  - A write to the buffer of the currently granted requester while busy=1 is ignored.
  - Writes to the other buffer are always accepted.
- Latched at grant: x_base, y_base, len_eff, owner. len_eff = min(lenN, MAX_LEN).
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins (last_owner register; reset value 1, so requester 0 wins first).
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
  - IDLE: if any req, latch winner and set idx=0. Go to DONE if len_eff=0, else ISSUE.
  - ISSUE: address = buf[owner][idx]; x_input = x_base + idx*CHAR_W, truncated to 9 bits (wraps mod 512); y_input = y_base. enable_character_plot = (state==ISSUE && ready_to_start_character). Move to WAIT_LO when the pulse fires.
  - WAIT_LO: wait for ready_to_start_character=0, then WAIT_HI.
  - WAIT_HI: wait for ready_to_start_character=1. Then idx+1; go to DONE if idx+1==len_eff, else ISSUE.
  - DONE: doneN=1 for one cycle; update last_owner; go to IDLE.
- A req still high after done is a fresh request and is re-arbitrated next IDLE cycle.
- address, x_input and y_input are driven 0 outside ISSUE.

## Timing
- Reset values: state IDLE, idx 0, last_owner 1, all outputs 0. Buffer contents are retained across reset.
- Reset asserted mid-line: next cycle in IDLE, plot pulse and gnt drop immediately, no done pulse. The drawer is not aborted.
- Request latency: req sampled high at edge k puts the block in ISSUE in cycle k+1. Plot pulses in cycle k+1 if ready is high.
- Per-character overhead beyond the drawer's busy time: 1 cycle (WAIT_HI→ISSUE). Back-to-back plots are at minimum 3 cycles apart.
- gntN is high from the first ISSUE cycle through the DONE cycle inclusive.
- len_eff=0: done pulse at cycle k+1, no plot issued.
- The handshake requires the drawer to drop ready at least one cycle after the start pulse. The block never issues while in WAIT_LO or WAIT_HI.
- Requester inputs (x, y, len) are ignored after grant.

## Test plan
- Single line: buf0 = {0x41,0x42,0x43}; len0=3, x0=10, y0=20; drawer model busy 5 cycles. Expect 3 pulses with (addr,x) = (0x41,10), (0x42,18), (0x43,26), all at y=20. Expect done0 one cycle after the third ready rise, and gnt1 never high.
- Contention: req0 and req1 high in the same cycle, len=2 each, held high. Expect order: line 0, line 1, line 0, line 1, with done pulses alternating.
- Boundaries:
  - len0=0: done0 at cycle k+1 with no plot.
  - len0=20: exactly 16 plots.
- x wrap: x0=500, len0=3. Expect x_input values 500, 508, 4.
- Reset at the second WAIT_HI: all outputs 0 the next cycle, no done. A new req0 then plots from idx 0.
- Write blocking: while line 0 is active, a wr_en0 to idx 1 is ignored (old data is plotted). A wr_en1 to buf1 during the same line is visible in the next line-1 plot.
